// File: rtl/offnariscv_ex_scheduler_pkg.sv
// Shared types for the EX-stage scheduler: unit select, FSM states,
// RF->EX / EX->unit / unit->WB payload bundles.
package offnariscv_ex_scheduler_pkg;

  localparam int XLEN  = 32;
  localparam int CMD_W = 4;
  localparam int NFU   = 4;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_SYS = 2'd2,
    FU_LSU = 2'd3
  } fu_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } ex_sched_state_e;

  typedef logic [CMD_W-1:0] cmd_t;
  typedef logic [XLEN-1:0]  xlen_t;

  localparam cmd_t ALU_ADD   = 4'd0;
  localparam cmd_t BRU_BEQ   = 4'd0;
  localparam cmd_t SYS_ECALL = 4'd1;
  localparam cmd_t LSU_LW    = 4'd2;

  typedef struct packed {
    xlen_t pc;
  } pcg_data_t;

  typedef struct packed {
    xlen_t trap_cause;
  } if_data_t;

  typedef struct packed {
    logic       alu_cmd_vld;
    cmd_t       alu_cmd;
    logic       bru_cmd_vld;
    cmd_t       bru_cmd;
    logic       sys_cmd_vld;
    cmd_t       sys_cmd;
    logic       lsu_cmd_vld;
    cmd_t       lsu_cmd;
    xlen_t      immediate;
    logic [4:0] rd;
  } id_data_t;

  typedef struct packed {
    pcg_data_t pcg_data;
    if_data_t  if_data;
    id_data_t  id_data;
    xlen_t     op1;
    xlen_t     op2;
    xlen_t     rs2_data;
    xlen_t     csr_rdata;
    xlen_t     mtvec;
    xlen_t     mepc;
  } rfex_tdata_t;

  typedef struct packed {
    xlen_t op1;
    xlen_t op2;
    cmd_t  alu_cmd;
  } rfalu_tdata_t;

  typedef struct packed {
    xlen_t op1;
    xlen_t op2;
    xlen_t immediate;
    xlen_t pc;
    cmd_t  bru_cmd;
  } rfbru_tdata_t;

  typedef struct packed {
    xlen_t op1;
    xlen_t op2;
    xlen_t csr_rdata;
    cmd_t  sys_cmd;
    xlen_t trap_cause;
    xlen_t pc;
    xlen_t mtvec;
    xlen_t mepc;
  } rfsys_tdata_t;

  typedef struct packed {
    xlen_t op1;
    xlen_t op2;
    xlen_t immediate;
    cmd_t  lsu_cmd;
  } rflsu_tdata_t;

  typedef struct packed {
    xlen_t result;
  } aluwb_tdata_t;

  typedef struct packed {
    xlen_t result;
    logic  taken;
    xlen_t new_pc;
  } bruwb_tdata_t;

  typedef struct packed {
    logic  trap;
    logic  use_new_pc;
    xlen_t new_pc;
    logic  csr_update;
    xlen_t csr_wdata;
  } syswb_tdata_t;

  typedef struct packed {
    xlen_t result;
    logic  trap;
  } lsuwb_tdata_t;

  typedef struct packed {
    xlen_t       wdata;
    rfex_tdata_t rf_data;
  } wbrf_tdata_t;

  typedef struct packed {
    xlen_t wdata;
    logic  trap;
    logic  redir;
    xlen_t redir_pc;
    logic  csr_we;
    xlen_t csr_wdata;
  } ex_res_t;

  function automatic logic [NFU-1:0] fu_onehot(input fu_sel_e sel);
    fu_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/offnariscv_ex_scheduler_if.sv
// EX-stage scheduler bus: RF input, per-unit request/result streams,
// WB output, redirect and stall-counter observation.
interface offnariscv_ex_scheduler_if
  import offnariscv_ex_scheduler_pkg::*;
#(
  parameter int STALL_CNT_WIDTH = 16
);

  logic                       s_rfex_tvalid;
  logic                       s_rfex_tready;
  rfex_tdata_t                s_rfex_tdata;

  logic [NFU-1:0]             m_fu_tvalid;
  logic [NFU-1:0]             m_fu_tready;
  rfalu_tdata_t               m_alu_tdata;
  rfbru_tdata_t               m_bru_tdata;
  rfsys_tdata_t               m_sys_tdata;
  rflsu_tdata_t               m_lsu_tdata;

  logic [NFU-1:0]             s_fu_tvalid;
  logic [NFU-1:0]             s_fu_tready;
  aluwb_tdata_t               s_alu_tdata;
  bruwb_tdata_t               s_bru_tdata;
  syswb_tdata_t               s_sys_tdata;
  lsuwb_tdata_t               s_lsu_tdata;

  logic                       m_exwb_tvalid;
  logic                       m_exwb_tready;
  wbrf_tdata_t                m_exwb_tdata;
  logic                       m_exwb_rd_we;
  logic                       m_exwb_csr_we;
  xlen_t                      m_exwb_csr_wdata;

  logic                       redirect_valid;
  xlen_t                      redirect_pc;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles;

  modport master (
    input  s_rfex_tvalid, s_rfex_tdata,
    output s_rfex_tready,
    output m_fu_tvalid,
    input  m_fu_tready,
    output m_alu_tdata, m_bru_tdata,
    output m_sys_tdata, m_lsu_tdata,
    input  s_fu_tvalid,
    output s_fu_tready,
    input  s_alu_tdata, s_bru_tdata,
    input  s_sys_tdata, s_lsu_tdata,
    output m_exwb_tvalid,
    input  m_exwb_tready,
    output m_exwb_tdata, m_exwb_rd_we,
    output m_exwb_csr_we, m_exwb_csr_wdata,
    output redirect_valid, redirect_pc,
    output stall_cycles
  );

  modport slave (
    output s_rfex_tvalid, s_rfex_tdata,
    input  s_rfex_tready,
    input  m_fu_tvalid,
    output m_fu_tready,
    input  m_alu_tdata, m_bru_tdata,
    input  m_sys_tdata, m_lsu_tdata,
    output s_fu_tvalid,
    input  s_fu_tready,
    output s_alu_tdata, s_bru_tdata,
    output s_sys_tdata, s_lsu_tdata,
    input  m_exwb_tvalid,
    output m_exwb_tready,
    input  m_exwb_tdata, m_exwb_rd_we,
    input  m_exwb_csr_we, m_exwb_csr_wdata,
    input  redirect_valid, redirect_pc,
    input  stall_cycles
  );

endinterface

// File: rtl/offnariscv_ex_fu_select.sv
// Picks the functional unit for an instruction from its cmd_vld flags.
// Instructions with no unit flag fall to SYS (trap / fence_i path).
module offnariscv_ex_fu_select
  import offnariscv_ex_scheduler_pkg::*;
(
  input  logic    alu_vld,
  input  logic    bru_vld,
  input  logic    sys_vld,
  input  logic    lsu_vld,
  output fu_sel_e sel
);

  always_comb begin
    sel = FU_SYS;
    priority case (1'b1)
      lsu_vld: sel = FU_LSU;
      sys_vld: sel = FU_SYS;
      bru_vld: sel = FU_BRU;
      alu_vld: sel = FU_ALU;
      default: sel = FU_SYS;
    endcase
  end

endmodule

// File: rtl/offnariscv_ex_scheduler.sv
// EX-stage controller: one instruction in flight, routed to one unit,
// result forwarded to WB with optional PC redirect.
module offnariscv_ex_scheduler
  import offnariscv_ex_scheduler_pkg::*;
#(
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  offnariscv_ex_scheduler_if.master bus
);

  ex_sched_state_e            state_q;
  ex_sched_state_e            state_d;
  fu_sel_e                    sel_d;
  fu_sel_e                    sel_q;
  rfex_tdata_t                rf_q;
  ex_res_t                    res_d;
  ex_res_t                    res_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic [NFU-1:0]             sel_oh;
  logic [NFU-1:0]             fu_req_vld;
  logic [NFU-1:0]             fu_res_rdy;
  logic                       rf_rdy;
  logic                       rf_ld;
  logic                       res_ld;
  logic                       exwb_vld;
  logic                       stall_inc;
  logic                       redir_fire;
  rfalu_tdata_t               alu_req;
  rfbru_tdata_t               bru_req;
  rfsys_tdata_t               sys_req;
  rflsu_tdata_t               lsu_req;

  offnariscv_ex_fu_select u_fu_select (
    .alu_vld (bus.s_rfex_tdata.id_data.alu_cmd_vld),
    .bru_vld (bus.s_rfex_tdata.id_data.bru_cmd_vld),
    .sys_vld (bus.s_rfex_tdata.id_data.sys_cmd_vld),
    .lsu_vld (bus.s_rfex_tdata.id_data.lsu_cmd_vld),
    .sel     (sel_d)
  );

  assign sel_oh = fu_onehot(sel_q);

  always_comb begin
    state_d    = state_q;
    rf_rdy     = 1'b0;
    rf_ld      = 1'b0;
    fu_req_vld = '0;
    fu_res_rdy = '0;
    res_ld     = 1'b0;
    exwb_vld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        rf_rdy = rst_n;
        if (bus.s_rfex_tvalid) begin
          rf_ld   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fu_req_vld = sel_oh;
        if (bus.m_fu_tready[sel_q]) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        fu_res_rdy = sel_oh;
        if (bus.s_fu_tvalid[sel_q]) begin
          res_ld  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        exwb_vld = 1'b1;
        if (bus.m_exwb_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fold the selected unit's result into one WB-ready record at capture.
  always_comb begin
    res_d = '0;
    unique case (sel_q)
      FU_ALU: begin
        res_d.wdata = bus.s_alu_tdata.result;
      end
      FU_BRU: begin
        res_d.wdata    = bus.s_bru_tdata.result;
        res_d.redir    = bus.s_bru_tdata.taken;
        res_d.redir_pc = bus.s_bru_tdata.new_pc;
      end
      FU_SYS: begin
        res_d.wdata     = rf_q.csr_rdata;
        res_d.trap      = bus.s_sys_tdata.trap;
        res_d.redir     = bus.s_sys_tdata.use_new_pc
                        | bus.s_sys_tdata.trap;
        res_d.redir_pc  = bus.s_sys_tdata.new_pc;
        res_d.csr_we    = bus.s_sys_tdata.csr_update
                        & ~bus.s_sys_tdata.trap;
        res_d.csr_wdata = bus.s_sys_tdata.csr_wdata;
      end
      FU_LSU: begin
        res_d.wdata    = bus.s_lsu_tdata.result;
        res_d.trap     = bus.s_lsu_tdata.trap;
        res_d.redir    = bus.s_lsu_tdata.trap;
        res_d.redir_pc = rf_q.mtvec;
      end
      default: res_d = '0;
    endcase
  end

  assign stall_inc = (state_q == ISSUE) || (state_q == WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_ld) begin
      rf_q  <= bus.s_rfex_tdata;
      sel_q <= sel_d;
    end
    if (res_ld) begin
      res_q <= res_d;
    end
  end

  always_comb begin
    alu_req            = '0;
    alu_req.op1        = rf_q.op1;
    alu_req.op2        = rf_q.op2;
    alu_req.alu_cmd    = rf_q.id_data.alu_cmd;

    bru_req            = '0;
    bru_req.op1        = rf_q.op1;
    bru_req.op2        = rf_q.op2;
    bru_req.immediate  = rf_q.id_data.immediate;
    bru_req.pc         = rf_q.pcg_data.pc;
    bru_req.bru_cmd    = rf_q.id_data.bru_cmd;

    sys_req            = '0;
    sys_req.op1        = rf_q.op1;
    sys_req.op2        = rf_q.op2;
    sys_req.csr_rdata  = rf_q.csr_rdata;
    sys_req.sys_cmd    = rf_q.id_data.sys_cmd;
    sys_req.trap_cause = rf_q.if_data.trap_cause;
    sys_req.pc         = rf_q.pcg_data.pc;
    sys_req.mtvec      = rf_q.mtvec;
    sys_req.mepc       = rf_q.mepc;

    // Stores carry rs2 as data; op2 is the address offset path elsewhere.
    lsu_req            = '0;
    lsu_req.op1        = rf_q.op1;
    lsu_req.op2        = rf_q.rs2_data;
    lsu_req.immediate  = rf_q.id_data.immediate;
    lsu_req.lsu_cmd    = rf_q.id_data.lsu_cmd;
  end

  assign redir_fire = exwb_vld & bus.m_exwb_tready & res_q.redir;

  assign bus.s_rfex_tready    = rf_rdy;
  assign bus.m_fu_tvalid      = fu_req_vld;
  assign bus.s_fu_tready      = fu_res_rdy;
  assign bus.m_alu_tdata      = alu_req;
  assign bus.m_bru_tdata      = bru_req;
  assign bus.m_sys_tdata      = sys_req;
  assign bus.m_lsu_tdata      = lsu_req;
  assign bus.m_exwb_tvalid    = exwb_vld;
  assign bus.m_exwb_tdata     = '{wdata: res_q.wdata, rf_data: rf_q};
  assign bus.m_exwb_rd_we     = (rf_q.id_data.rd != 5'd0) & ~res_q.trap;
  assign bus.m_exwb_csr_we    = res_q.csr_we;
  assign bus.m_exwb_csr_wdata = res_q.csr_wdata;
  assign bus.redirect_valid   = redir_fire;
  assign bus.redirect_pc      = redir_fire ? res_q.redir_pc : '0;
  assign bus.stall_cycles     = stall_q;

endmodule

// File: tb/tb_offnariscv_ex_scheduler.sv
// Bench for the EX scheduler: directed vector table, reset corner case,
// then random instructions checked against a rule-level model.
module tb_offnariscv_ex_scheduler;
  import offnariscv_ex_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  offnariscv_ex_scheduler_if #(.STALL_CNT_WIDTH(16)) bus ();

  offnariscv_ex_scheduler #(.STALL_CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] bru;
    bit          taken;
    logic [31:0] bpc;
    bit          strap;
    bit          snew;
    logic [31:0] spc;
    bit          supd;
    logic [31:0] swd;
    logic [31:0] lsu;
    bit          ltrap;
  } res_t;

  typedef struct {
    int          sel;
    logic [31:0] wdata;
    bit          rd_we;
    bit          csr_we;
    logic [31:0] csr_wd;
    bit          redir;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] csr;
    logic [31:0] mtvec;
    res_t        r;
    int          iw;
    int          rw;
    int          ow;
    bit          stray;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t mkr(int alu, int bru, int tk, int bpc,
                               int st, int sn, int spc, int su,
                               int swd, int lsu, int lt);
    res_t r;
    r.alu = 32'(alu);  r.bru = 32'(bru);  r.taken = tk != 0;
    r.bpc = 32'(bpc);  r.strap = st != 0; r.snew = sn != 0;
    r.spc = 32'(spc);  r.supd = su != 0;  r.swd = 32'(swd);
    r.lsu = 32'(lsu);  r.ltrap = lt != 0;
    return r;
  endfunction

  function automatic exp_t mke(int sel, int wd, int rw, int cw,
                               int cwd, int rv, int rpc);
    exp_t e;
    e.sel = sel;        e.wdata = 32'(wd);   e.rd_we = rw != 0;
    e.csr_we = cw != 0; e.csr_wd = 32'(cwd); e.redir = rv != 0;
    e.rpc = 32'(rpc);
    return e;
  endfunction

  function automatic vec_t mkv(int vld, int op1, int op2, int rd,
                               int pc, int imm, int csr, int mtvec,
                               res_t r, int iw, int rw, int ow,
                               int stray, exp_t e);
    vec_t v;
    v.vld = 4'(vld);  v.op1 = 32'(op1); v.op2 = 32'(op2);
    v.rd = 5'(rd);    v.pc = 32'(pc);   v.imm = 32'(imm);
    v.csr = 32'(csr); v.mtvec = 32'(mtvec);
    v.r = r; v.iw = iw; v.rw = rw; v.ow = ow;
    v.stray = stray != 0; v.e = e;
    return v;
  endfunction

  // Reference: unit choice by priority, then the per-unit WB rules.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    bit   trap;
    e = mke(2, 0, 0, 0, 0, 0, 0);
    trap = 1'b0;
    if (v.vld[3])      e.sel = 3;
    else if (v.vld[2]) e.sel = 2;
    else if (v.vld[1]) e.sel = 1;
    else if (v.vld[0]) e.sel = 0;
    else               e.sel = 2;
    case (e.sel)
      0: e.wdata = v.r.alu;
      1: begin
        e.wdata = v.r.bru;
        e.redir = v.r.taken;
        e.rpc   = v.r.bpc;
      end
      2: begin
        e.wdata  = v.csr;
        trap     = v.r.strap;
        e.redir  = v.r.snew || v.r.strap;
        e.rpc    = v.r.spc;
        e.csr_we = v.r.supd && !v.r.strap;
        e.csr_wd = v.r.swd;
      end
      default: begin
        e.wdata = v.r.lsu;
        trap    = v.r.ltrap;
        e.redir = v.r.ltrap;
        e.rpc   = v.mtvec;
      end
    endcase
    e.rd_we = (v.rd != 0) && !trap;
    if (!e.redir) e.rpc = '0;
    return e;
  endfunction

  function automatic rfex_tdata_t mk_ins(input vec_t v);
    rfex_tdata_t t;
    t = '0;
    t.id_data.alu_cmd_vld = v.vld[0];
    t.id_data.bru_cmd_vld = v.vld[1];
    t.id_data.sys_cmd_vld = v.vld[2];
    t.id_data.lsu_cmd_vld = v.vld[3];
    t.id_data.alu_cmd     = ALU_ADD;
    t.id_data.bru_cmd     = BRU_BEQ;
    t.id_data.sys_cmd     = SYS_ECALL;
    t.id_data.lsu_cmd     = LSU_LW;
    t.id_data.immediate   = v.imm;
    t.id_data.rd          = v.rd;
    t.pcg_data.pc         = v.pc;
    t.if_data.trap_cause  = 32'd11;
    t.op1                 = v.op1;
    t.op2                 = v.op2;
    t.rs2_data            = v.op2 ^ 32'h5a5a_5a5a;
    t.csr_rdata           = v.csr;
    t.mtvec               = v.mtvec;
    t.mepc                = v.pc + 32'd8;
    return t;
  endfunction

  task automatic drive_res(input res_t r);
    bus.s_alu_tdata.result     = r.alu;
    bus.s_bru_tdata.result     = r.bru;
    bus.s_bru_tdata.taken      = r.taken;
    bus.s_bru_tdata.new_pc     = r.bpc;
    bus.s_sys_tdata.trap       = r.strap;
    bus.s_sys_tdata.use_new_pc = r.snew;
    bus.s_sys_tdata.new_pc     = r.spc;
    bus.s_sys_tdata.csr_update = r.supd;
    bus.s_sys_tdata.csr_wdata  = r.swd;
    bus.s_lsu_tdata.result     = r.lsu;
    bus.s_lsu_tdata.trap       = r.ltrap;
  endtask

  task automatic chk_payload(input vec_t v);
    case (v.e.sel)
      0: begin
        chk("alu_op1", bus.m_alu_tdata.op1, v.op1);
        chk("alu_op2", bus.m_alu_tdata.op2, v.op2);
        chk("alu_cmd", bus.m_alu_tdata.alu_cmd, ALU_ADD);
      end
      1: begin
        chk("bru_pc", bus.m_bru_tdata.pc, v.pc);
        chk("bru_imm", bus.m_bru_tdata.immediate, v.imm);
      end
      2: begin
        chk("sys_pc", bus.m_sys_tdata.pc, v.pc);
        chk("sys_mtvec", bus.m_sys_tdata.mtvec, v.mtvec);
      end
      default: begin
        chk("lsu_op1", bus.m_lsu_tdata.op1, v.op1);
        chk("lsu_op2", bus.m_lsu_tdata.op2,
            v.op2 ^ 32'h5a5a_5a5a);
        chk("lsu_imm", bus.m_lsu_tdata.immediate, v.imm);
      end
    endcase
  endtask

  // Plays RF, the selected unit and WB for one instruction.
  task automatic do_op(input vec_t v);
    logic [3:0] oh;
    logic [3:0] sv;
    int         base;
    oh = 4'b0001 << v.e.sel;
    sv = v.stray ? 4'b1000 : 4'b0000;
    @(negedge clk);
    bus.s_rfex_tvalid = 1'b1;
    bus.s_rfex_tdata  = mk_ins(v);
    bus.m_fu_tready   = 4'b0000;
    bus.s_fu_tvalid   = sv;
    bus.m_exwb_tready = 1'b0;
    drive_res(v.r);
    #1;
    chk("rf_ready", bus.s_rfex_tready, 1);
    base = int'(bus.stall_cycles);
    for (int i = 0; i <= v.iw; i++) begin
      @(negedge clk);
      bus.s_rfex_tvalid = 1'b0;
      bus.s_rfex_tdata  = '0;
      bus.m_fu_tready   = (i == v.iw) ? 4'hf : ~oh;
      #1;
      chk("fu_tvalid", bus.m_fu_tvalid, oh);
      chk("exwb_early", bus.m_exwb_tvalid, 0);
      chk("fu_rdy_issue", bus.s_fu_tready, 0);
      chk_payload(v);
    end
    for (int j = 0; j <= v.rw; j++) begin
      @(negedge clk);
      bus.m_fu_tready = 4'b0000;
      bus.s_fu_tvalid = sv | ((j == v.rw) ? oh : 4'b0000);
      #1;
      chk("fu_rready", bus.s_fu_tready, oh);
      chk("fu_tvalid_wait", bus.m_fu_tvalid, 0);
      chk("exwb_wait", bus.m_exwb_tvalid, 0);
    end
    for (int k = 0; k <= v.ow; k++) begin
      @(negedge clk);
      bus.s_fu_tvalid   = sv;
      bus.m_exwb_tready = (k == v.ow);
      #1;
      chk("exwb_valid", bus.m_exwb_tvalid, 1);
      chk("wdata", bus.m_exwb_tdata.wdata, v.e.wdata);
      chk("rd", bus.m_exwb_tdata.rf_data.id_data.rd, v.rd);
      chk("rd_we", bus.m_exwb_rd_we, v.e.rd_we);
      chk("csr_we", bus.m_exwb_csr_we, v.e.csr_we);
      if (v.e.sel == 2)
        chk("csr_wdata", bus.m_exwb_csr_wdata, v.e.csr_wd);
      chk("redir_valid", bus.redirect_valid,
          (k == v.ow) && v.e.redir);
      if (k == v.ow)
        chk("redir_pc", bus.redirect_pc, v.e.rpc);
      chk("rf_ready_out", bus.s_rfex_tready, 0);
      chk("fu_rdy_out", bus.s_fu_tready, 0);
      if (k == 0)
        chk("stall", bus.stall_cycles,
            64'(base + v.iw + v.rw + 2));
    end
    @(negedge clk);
    bus.m_exwb_tready = 1'b0;
    bus.s_fu_tvalid   = 4'b0000;
    #1;
    chk("exwb_done", bus.m_exwb_tvalid, 0);
    chk("redir_done", bus.redirect_valid, 0);
    chk("rf_ready_idle", bus.s_rfex_tready, 1);
  endtask

  vec_t tv[9];
  vec_t rv;
  res_t z;

  initial begin
    bus.s_rfex_tvalid = 1'b0;
    bus.s_rfex_tdata  = '0;
    bus.m_fu_tready   = 4'b0000;
    bus.s_fu_tvalid   = 4'b0000;
    bus.m_exwb_tready = 1'b0;
    z = mkr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_res(z);

    tv[0] = mkv(4'b0001, 5, 7, 3, 32'h40, 0, 0, 32'h8000_0000,
                mkr(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
                mke(0, 12, 1, 0, 0, 0, 0));
    tv[1] = mkv(4'b0010, 9, 9, 0, 32'h100, 32'h20, 0, 0,
                mkr(0, 32'h104, 1, 32'h120, 0, 0, 0, 0, 0, 0, 0),
                0, 0, 0, 0, mke(1, 32'h104, 0, 0, 0, 1, 32'h120));
    tv[2] = mkv(4'b1001, 32'h1000, 32'h10, 5, 32'h200, 4, 0,
                32'h8000_0000,
                mkr(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hdead_beef, 0),
                4, 1, 0, 0, mke(3, 32'hdead_beef, 1, 0, 0, 0, 0));
    tv[3] = mkv(4'b0100, 0, 0, 1, 32'h300, 0, 32'h55,
                32'h8000_0000,
                mkr(0, 0, 0, 0, 1, 0, 32'h8000_0000, 1, 32'h77, 0, 0),
                0, 0, 0, 0,
                mke(2, 32'h55, 0, 0, 32'h77, 1, 32'h8000_0000));
    tv[4] = mkv(4'b0001, 100, 23, 7, 32'h44, 0, 0, 0,
                mkr(123, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 2, 0, 1,
                mke(0, 123, 1, 0, 0, 0, 0));
    tv[5] = mkv(4'b0000, 0, 0, 0, 32'h1fc, 0, 32'h11, 0,
                mkr(0, 0, 0, 0, 0, 1, 32'h200, 1, 32'habc, 0, 0),
                0, 0, 0, 0, mke(2, 32'h11, 0, 1, 32'habc, 1, 32'h200));
    tv[6] = mkv(4'b1000, 8, 8, 9, 32'h400, 0, 0, 32'h8000_0040,
                mkr(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 1), 1, 2, 1,
                0, mke(3, 32'h1234, 0, 0, 0, 1, 32'h8000_0040));
    tv[7] = mkv(4'b0010, 1, 2, 2, 32'h300, 32'h40, 0, 0,
                mkr(0, 32'h304, 0, 32'h999, 0, 0, 0, 0, 0, 0, 0),
                0, 0, 2, 0, mke(1, 32'h304, 1, 0, 0, 0, 0));
    tv[8] = mkv(4'b0111, 3, 4, 3, 32'h500, 0, 32'h22, 0,
                mkr(7, 8, 1, 32'h9, 0, 0, 0, 0, 5, 0, 0), 0, 0, 0, 0,
                mke(2, 32'h22, 1, 0, 5, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rf_ready", bus.s_rfex_tready, 0);
    chk("rst_fu_tvalid", bus.m_fu_tvalid, 0);
    chk("rst_fu_tready", bus.s_fu_tready, 0);
    chk("rst_exwb", bus.m_exwb_tvalid, 0);
    chk("rst_redir", bus.redirect_valid, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", bus.s_rfex_tready, 1);

    for (int n = 0; n < 9; n++) do_op(tv[n]);

    // Reset while waiting on the unit: old op must vanish.
    @(negedge clk);
    rv = mkv(4'b0001, 1, 2, 4, 0, 0, 0, 0,
             mkr(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
             mke(0, 3, 1, 0, 0, 0, 0));
    bus.s_rfex_tvalid = 1'b1;
    bus.s_rfex_tdata  = mk_ins(rv);
    bus.m_fu_tready   = 4'hf;
    drive_res(rv.r);
    @(negedge clk);
    bus.s_rfex_tvalid = 1'b0;
    @(negedge clk);
    bus.m_fu_tready = 4'h0;
    #1;
    chk("rw_in_wait", bus.s_fu_tready, 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_stall_clr", bus.stall_cycles, 0);
    chk("rw_fu_tready", bus.s_fu_tready, 0);
    chk("rw_ready", bus.s_rfex_tready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_fu_tvalid = 4'b0001;
      #1;
      chk("rw_no_exwb", bus.m_exwb_tvalid, 0);
      chk("rw_no_req", bus.m_fu_tvalid, 0);
    end
    bus.s_fu_tvalid = 4'b0000;
    rv = mkv(4'b0001, 40, 2, 6, 0, 0, 0, 0,
             mkr(42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
             mke(0, 42, 1, 0, 0, 0, 0));
    do_op(rv);

    for (int n = 0; n < 40; n++) begin
      rv.vld   = 4'($urandom_range(0, 15));
      rv.op1   = $urandom;
      rv.op2   = $urandom;
      rv.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rv.pc    = $urandom & 32'hffff_fffc;
      rv.imm   = $urandom;
      rv.csr   = $urandom;
      rv.mtvec = $urandom & 32'hffff_fffc;
      rv.r = mkr(int'($urandom), int'($urandom),
                 int'($urandom_range(0, 1)), int'($urandom),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), int'($urandom),
                 int'($urandom_range(0, 1)), int'($urandom),
                 int'($urandom), int'($urandom_range(0, 1)));
      rv.iw = $urandom_range(0, 3);
      rv.rw = $urandom_range(0, 3);
      rv.ow = $urandom_range(0, 2);
      rv.stray = 1'b0;
      rv.e  = model(rv);
      rv.stray = (rv.e.sel != 3) && ($urandom_range(0, 1) == 1);
      do_op(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
